loba_term_sequencer: RTL and testbench

LOBA_TERM_SEQUENCER -- requirements
Module: loba_term_sequencer

---
 rtl/loba_term_sequencer_pkg.sv | 35 +++
 rtl/loba_term_sequencer_if.sv | 34 +++
 rtl/loba_term_sequencer_leading_one_bit.sv | 29 ++
 rtl/loba_term_sequencer.sv | 143 ++++++++++++++
 tb/tb_loba_term_sequencer.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/loba_term_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : loba_pkg
// Description : Shared definitions for the leading-one term sequencer:
//               FSM state encoding, operand width and the one-hot to
//               binary index helper used to form the shift amount.
// Ports       : none (package)
// Config      : LOBA_TERM_SEQ_SWAP_EN (used by loba_term_sequencer)
// Revision    : 1.0 - initial release
// ============================================================================
package loba_pkg;

    localparam int LOBA_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } loba_state_t;

    // Input is expected to be one-hot (or zero); OR-ing the indices of set
    // bits yields the position without needing a priority chain.
    function automatic logic [3:0] onehot_to_index(input logic [LOBA_WIDTH-1:0] onehot);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < LOBA_WIDTH; i++) begin
            if (onehot[i]) begin
                idx = idx | 4'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/loba_term_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : loba_term_sequencer_if
// Description : Operand/result handshake bundle for loba_term_sequencer.
//               master : producer/consumer side (drives in_valid, a, b,
//                        out_ready)
//               slave  : sequencer side (drives in_ready, out_valid, p,
//                        terms_used)
// Revision    : 1.0 - initial release
// ============================================================================
interface loba_term_sequencer_if;
    import loba_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [LOBA_WIDTH-1:0] a;
    logic [LOBA_WIDTH-1:0] b;
    logic                  out_valid;
    logic                  out_ready;
    logic [31:0]           p;
    logic [4:0]            terms_used;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, p, terms_used
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, p, terms_used
    );

endinterface
`default_nettype wire

// File: rtl/loba_term_sequencer_leading_one_bit.sv
`default_nettype none
// ============================================================================
// Module      : LEADING_ONE_BIT
// Description : Isolates the most significant set bit of x as a one-hot
//               vector y (all zeros when x is zero).
// Ports       : x - input vector
//               y - one-hot of the highest set bit of x
// Revision    : 1.0 - initial release
// ============================================================================
module LEADING_ONE_BIT #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y
);

    // Ascending scan: the last (highest) set bit found overwrites lower ones.
    always_comb begin
        y = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (x[i]) begin
                y    = '0;
                y[i] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/loba_term_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : loba_term_sequencer
// Description : Approximate multiplier that decomposes the multiplicand into
//               leading-one terms and accumulates up to TERMS shifted copies
//               of the multiplier, one term per clock.
// Ports       : clk  - clock, rising edge
//               rst  - synchronous active-high reset
//               bus  - loba_term_sequencer_if.slave
//                      (in_valid/in_ready/a/b, out_valid/out_ready/p/
//                      terms_used)
// Parameters  : TERMS - maximum terms accumulated per operation (1..16)
// Config      : LOBA_TERM_SEQ_SWAP_EN - when defined, the smaller operand is
//               decomposed so fewer terms are needed for a given accuracy.
// Revision    : 1.0 - initial release
// ============================================================================
module loba_term_sequencer
    import loba_pkg::*;
#(
    parameter int TERMS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    loba_term_sequencer_if.slave  bus
);

    localparam logic [4:0] c_terms = 5'(TERMS);

    loba_state_t           r_state;
    loba_state_t           w_state_next;
    logic [LOBA_WIDTH-1:0] r_r;
    logic [LOBA_WIDTH-1:0] r_b;
    logic [31:0]           r_acc;
    logic [4:0]            r_cnt;
    logic                  r_out_valid;
    logic [31:0]           r_p;
    logic [4:0]            r_terms;

    logic [LOBA_WIDTH-1:0] w_lead;
    logic [3:0]            w_idx;
    logic                  w_run_end;
    logic [LOBA_WIDTH-1:0] w_load_r;
    logic [LOBA_WIDTH-1:0] w_load_b;

    LEADING_ONE_BIT #(
        .WIDTH (LOBA_WIDTH)
    ) u_leading_one (
        .x (r_r),
        .y (w_lead)
    );

    assign w_idx     = onehot_to_index(w_lead);
    assign w_run_end = (r_r == '0) || (r_cnt == c_terms);

`ifdef LOBA_TERM_SEQ_SWAP_EN
    logic w_swap;
    assign w_swap   = bus.a > bus.b;
    assign w_load_r = w_swap ? bus.b : bus.a;
    assign w_load_b = w_swap ? bus.a : bus.b;
`else
    assign w_load_r = bus.a;
    assign w_load_b = bus.b;
`endif

    // Next-state and handshake outputs
    always_comb begin
        w_state_next = r_state;
        bus.in_ready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_run_end) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (r_out_valid && bus.out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign bus.out_valid  = r_out_valid;
    assign bus.p          = r_p;
    assign bus.terms_used = r_terms;

    // The result registers are loaded on the first DONE cycle and out_valid
    // rises one cycle after entering DONE; they then hold until consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_r         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_p         <= '0;
            r_terms     <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_r   <= w_load_r;
                        r_b   <= w_load_b;
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    if (!w_run_end) begin
                        r_acc <= r_acc + ({16'b0, r_b} << w_idx);
                        r_r   <= r_r & ~w_lead;
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                ST_DONE: begin
                    if (r_out_valid) begin
                        if (bus.out_ready) begin
                            r_out_valid <= 1'b0;
                        end
                    end else begin
                        r_out_valid <= 1'b1;
                        r_p         <= r_acc;
                        r_terms     <= r_cnt;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_loba_term_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_loba_term_sequencer
// Description : Directed self-checking bench for loba_term_sequencer with
//               TERMS=2 (main instance) and TERMS=16 (full-precision case).
//               Expected values depend on LOBA_TERM_SEQ_SWAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_loba_term_sequencer;
    import loba_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    loba_term_sequencer_if bus2();
    loba_term_sequencer_if bus16();

    loba_term_sequencer #(.TERMS(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    loba_term_sequencer #(.TERMS(16)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
        logic [4:0]  t;
        int          lat;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one operation on the TERMS=2 instance and wait for its result.
    // Phase: entered and left at #1 after a rising edge.
    task automatic op2(input logic [15:0] a, input logic [15:0] b,
                       output logic [31:0] p, output logic [4:0] t, output int lat);
        int guard;
        guard = 0;
        while (bus2.in_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        bus2.a        = a;
        bus2.b        = b;
        bus2.in_valid = 1'b1;
        @(posedge clk); #1;
        bus2.in_valid = 1'b0;
        lat = 0;
        while (bus2.out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        p = bus2.p;
        t = bus2.terms_used;
    endtask

    task automatic consume2();
        bus2.out_ready = 1'b1;
        @(posedge clk); #1;
        bus2.out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] p;
        logic [4:0]  t;
        int          lat;
        logic        seen;

        vecs[0] = '{16'h0000, 16'h1234, 32'h0000_0000, 5'd0, 2};
        vecs[1] = '{16'h0005, 16'h0003, 32'd15,        5'd2, 4};
        vecs[2] = '{16'h00FF, 16'h0100, 32'h0000_C000, 5'd2, 4};
`ifdef LOBA_TERM_SEQ_SWAP_EN
        vecs[3] = '{16'hFFFF, 16'h0003, 32'h0002_FFFD, 5'd2, 4};
        vecs[4] = '{16'h0007, 16'h0001, 32'd7,         5'd1, 3};
`else
        vecs[3] = '{16'hFFFF, 16'h0003, 32'h0002_4000, 5'd2, 4};
        vecs[4] = '{16'h0007, 16'h0001, 32'd6,         5'd2, 4};
`endif
        vecs[5] = '{16'h8000, 16'h0002, 32'h0001_0000, 5'd1, 3};
        vecs[6] = '{16'h0003, 16'h0007, 32'd21,        5'd2, 4};

        rst             = 1'b1;
        bus2.in_valid   = 1'b0;
        bus2.a          = '0;
        bus2.b          = '0;
        bus2.out_ready  = 1'b0;
        bus16.in_valid  = 1'b0;
        bus16.a         = '0;
        bus16.b         = '0;
        bus16.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus2.out_valid), 32'd0);
        check("rst_p", bus2.p, 32'd0);
        check("rst_terms", 32'(bus2.terms_used), 32'd0);
        check("rst_in_ready", 32'(bus2.in_ready), 32'd1);
        check("rst16_out_valid", 32'(bus16.out_valid), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Table-driven operations
        for (int i = 0; i < 7; i++) begin
            op2(vecs[i].a, vecs[i].b, p, t, lat);
            check($sformatf("v%0d_p", i), p, vecs[i].p);
            check($sformatf("v%0d_terms", i), 32'(t), 32'(vecs[i].t));
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            consume2();
            check($sformatf("v%0d_valid_drop", i), 32'(bus2.out_valid), 32'd0);
            check($sformatf("v%0d_idle_ready", i), 32'(bus2.in_ready), 32'd1);
        end

        // Full-precision product on the TERMS=16 instance
        bus16.a        = 16'hFFFF;
        bus16.b        = 16'hFFFF;
        bus16.in_valid = 1'b1;
        @(posedge clk); #1;
        bus16.in_valid = 1'b0;
        lat = 0;
        while (bus16.out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("t16_p", bus16.p, 32'hFFFE_0001);
        check("t16_terms", 32'(bus16.terms_used), 32'd16);
        check("t16_latency", 32'(lat), 32'd18);
        bus16.out_ready = 1'b1;
        @(posedge clk); #1;
        bus16.out_ready = 1'b0;
        check("t16_valid_drop", 32'(bus16.out_valid), 32'd0);

        // Backpressure: result holds, second operand ignored
        op2(16'h0005, 16'h0003, p, t, lat);
        check("bp_p", p, 32'd15);
        bus2.a        = 16'h00FF;
        bus2.b        = 16'h0100;
        bus2.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp%0d_valid", k), 32'(bus2.out_valid), 32'd1);
            check($sformatf("bp%0d_p", k), bus2.p, 32'd15);
            check($sformatf("bp%0d_terms", k), 32'(bus2.terms_used), 32'd2);
            check($sformatf("bp%0d_in_ready", k), 32'(bus2.in_ready), 32'd0);
            @(posedge clk); #1;
        end
        bus2.in_valid = 1'b0;
        consume2();
        check("bp_valid_drop", 32'(bus2.out_valid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp_no_queue%0d", k), 32'(bus2.in_ready), 32'd1);
            @(posedge clk); #1;
        end

        // Reset during the second RUN cycle aborts the operation
        bus2.a        = 16'h0005;
        bus2.b        = 16'h0003;
        bus2.in_valid = 1'b1;
        @(posedge clk); #1;
        bus2.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_in_ready", 32'(bus2.in_ready), 32'd1);
        check("abort_out_valid", 32'(bus2.out_valid), 32'd0);
        check("abort_p", bus2.p, 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (bus2.out_valid === 1'b1) seen = 1'b1;
            @(posedge clk); #1;
        end
        check("abort_no_result", 32'(seen), 32'd0);
        op2(16'h0005, 16'h0003, p, t, lat);
        check("post_abort_p", p, 32'd15);
        check("post_abort_terms", 32'(t), 32'd2);
        check("post_abort_latency", 32'(lat), 32'd4);
        consume2();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
